// File: rtl/acc_prod_9_if.sv
//==============================================================================
// Module : read_interface / write_interface
// Purpose: Tagged multi-flux FIFO handshake bundles used around acc_prod_9.
//          read_interface : per-flux empty flags in, per-flux read strobes out,
//                           shared data word in (from the FIFO side).
//          write_interface: per-flux full flags in, single write strobe and
//                           tagged data word out.
// Ports  : (interface members)
//          read_interface  : empty[FLUX-1:0], read[FLUX-1:0], dout[WIDTH-1:0]
//          write_interface : full[FLUX-1:0],  write,          din[WIDTH-1:0]
// Modports: actor/master = block consuming/producing the stream,
//           slave         = FIFO side.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

interface read_interface #(
   parameter int FLUX  = 2,
   parameter int WIDTH = 19
);
   logic [FLUX-1:0]  empty;
   logic [FLUX-1:0]  read;
   logic [WIDTH-1:0] dout;

   modport actor  (input empty, input dout, output read);
   modport master (input empty, input dout, output read);
   modport slave  (output empty, output dout, input read);
endinterface

interface write_interface #(
   parameter int FLUX  = 2,
   parameter int WIDTH = 22
);
   logic [FLUX-1:0]  full;
   logic             write;
   logic [WIDTH-1:0] din;

   modport actor  (input full, output write, output din);
   modport master (input full, output write, output din);
   modport slave  (output full, input write, input din);
endinterface

`default_nettype wire

// File: rtl/acc_prod_9.sv
//==============================================================================
// Module : acc_prod_9
// Purpose: Per-flux tap accumulator. Sums TAPS consecutive signed products of
//          each tagged flux and emits one tagged sum per group. One flux is
//          serviced per cycle, lowest index first. The final product of a
//          group is read and its sum written in the same cycle.
// Ports  : clk             - clock, rising edge
//          rst             - synchronous active-high reset
//          read_port_prod  - product stream in (empty in, read out, dout in)
//          write_port_sum  - tap-sum stream out (full in, write out, din out)
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

module acc_prod_9 #(
   parameter int FLUX            = 2,
   parameter int TAPS            = 8,
   parameter int TAG_WIDTH       = $clog2(FLUX),
   parameter int DATA_WIDTH_PROD = 18,
   parameter int DATA_WIDTH_SUM  = DATA_WIDTH_PROD + $clog2(TAPS)
) (
   input  logic           clk,
   input  logic           rst,
   read_interface.actor   read_port_prod,
   write_interface.actor  write_port_sum
);

   localparam int CNT_W = ($clog2(TAPS) < 1) ? 1 : $clog2(TAPS);
   localparam int EXT_W = DATA_WIDTH_SUM - DATA_WIDTH_PROD;
   localparam logic [CNT_W-1:0] C_LAST = CNT_W'(TAPS - 1);

   logic [DATA_WIDTH_SUM-1:0] acc_q [FLUX];
   logic [DATA_WIDTH_SUM-1:0] acc_d [FLUX];
   logic [CNT_W-1:0]          cnt_q [FLUX];
   logic [CNT_W-1:0]          cnt_d [FLUX];

   logic [FLUX-1:0]           eligible;
   logic [DATA_WIDTH_SUM-1:0] prod_ext;
   logic [DATA_WIDTH_SUM-1:0] sum;
   logic                      found;
   logic [FLUX-1:0]           read_vec;
   logic                      write_bit;
   logic [DATA_WIDTH_SUM+TAG_WIDTH-1:0] din_vec;

   // Tag bits of the incoming word carry no information here; the flux is
   // identified by which read strobe is raised.
   logic unused_tag;
   assign unused_tag = ^read_port_prod.dout[DATA_WIDTH_PROD+TAG_WIDTH-1:DATA_WIDTH_PROD];

   assign prod_ext = {{EXT_W{read_port_prod.dout[DATA_WIDTH_PROD-1]}},
                      read_port_prod.dout[DATA_WIDTH_PROD-1:0]};

   // A flux may proceed mid-group even when its output is full; only the
   // group-closing product needs room downstream.
   for (genvar g = 0; g < FLUX; g++) begin : g_elig
      assign eligible[g] = !read_port_prod.empty[g] &&
                           ((cnt_q[g] < C_LAST) || !write_port_sum.full[g]);
   end

   always_comb begin
      acc_d     = acc_q;
      cnt_d     = cnt_q;
      read_vec  = '0;
      write_bit = 1'b0;
      din_vec   = '0;
      found     = 1'b0;
      sum       = '0;
      if (!rst) begin
         for (int i = 0; i < FLUX; i++) begin
            if (!found && eligible[i]) begin
               found       = 1'b1;
               read_vec[i] = 1'b1;
               sum         = acc_q[i] + prod_ext;
               if (cnt_q[i] == C_LAST) begin
                  write_bit = 1'b1;
                  din_vec   = {TAG_WIDTH'(i), sum};
                  acc_d[i]  = '0;
                  cnt_d[i]  = '0;
               end else begin
                  acc_d[i]  = sum;
                  cnt_d[i]  = cnt_q[i] + CNT_W'(1);
               end
            end
         end
      end
   end

   assign read_port_prod.read  = read_vec;
   assign write_port_sum.write = write_bit;
   assign write_port_sum.din   = din_vec;

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < FLUX; i++) begin
            acc_q[i] <= '0;
            cnt_q[i] <= '0;
         end
      end else begin
         acc_q <= acc_d;
         cnt_q <= cnt_d;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_acc_prod_9.sv
//==============================================================================
// Module : tb_acc_prod_9
// Purpose: Directed self-checking bench for acc_prod_9 (FLUX=2, TAPS=8).
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

module tb_acc_prod_9;

   localparam int FLUX = 2;
   localparam int TAPS = 8;

   logic clk;
   logic rst;
   int   n_tests;
   int   n_fail;

   read_interface  #(.FLUX(FLUX), .WIDTH(19)) rd_if ();
   write_interface #(.FLUX(FLUX), .WIDTH(22)) wr_if ();

   acc_prod_9 #(.FLUX(FLUX), .TAPS(TAPS)) dut (
      .clk            (clk),
      .rst            (rst),
      .read_port_prod (rd_if),
      .write_port_sum (wr_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Apply inputs, check combinational outputs, then advance one clock.
   task automatic cyc(input string tag, input logic [1:0] emp, input logic [1:0] ful,
                      input logic [17:0] prod, input logic [1:0] exp_rd,
                      input logic exp_wr, input logic [21:0] exp_din);
      rd_if.empty = emp;
      wr_if.full  = ful;
      rd_if.dout  = {1'b1, prod};
      #1;
      check({tag, ".read"},  64'(rd_if.read),  64'(exp_rd));
      check({tag, ".write"}, 64'(wr_if.write), 64'(exp_wr));
      if (exp_wr)
         check({tag, ".din"}, 64'(wr_if.din), 64'(exp_din));
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_tests     = 0;
      n_fail      = 0;
      rst         = 1'b1;
      rd_if.empty = 2'b00;
      rd_if.dout  = '0;
      wr_if.full  = 2'b00;
      @(posedge clk);
      #1;
      // Outputs held low during reset even with data available.
      cyc("rst_out", 2'b00, 2'b00, 18'd5, 2'b00, 1'b0, 22'd0);
      rst = 1'b0;
      check("rst_acc0", 64'(dut.acc_q[0]), 64'd0);
      check("rst_cnt0", 64'(dut.cnt_q[0]), 64'd0);

      // Nothing available -> idle.
      cyc("idle", 2'b11, 2'b00, 18'd7, 2'b00, 1'b0, 22'd0);

      // Flux0 1..8 -> 36.
      for (int k = 1; k <= 8; k++)
         cyc("f0_seq", 2'b10, 2'b00, 18'(k), 2'b01, (k == 8), 22'd36);
      check("f0_acc_clr", 64'(dut.acc_q[0]), 64'd0);
      check("f0_cnt_clr", 64'(dut.cnt_q[0]), 64'd0);

      // Flux1 eight of -131072 -> -1048576 tagged 1.
      for (int k = 1; k <= 8; k++)
         cyc("f1_min", 2'b01, 2'b00, 18'h20000, 2'b10, (k == 8), 22'h300000);

      // Interleaved: flux0 wins whenever non-empty.
      for (int k = 0; k < 16; k++) begin
         if (k % 2 == 0)
            cyc("ilv_f0", 2'b00, 2'b00, 18'd2, 2'b01, (k == 14), 22'd16);
         else
            cyc("ilv_f1", 2'b01, 2'b00, 18'h3FFFF, 2'b10, (k == 15), 22'h3FFFF8);
      end

      // Flux0 to cnt=7, then blocked by full while flux1 accumulates.
      for (int k = 0; k < 7; k++)
         cyc("blk_fill", 2'b10, 2'b00, 18'd10, 2'b01, 1'b0, 22'd0);
      for (int k = 0; k < 3; k++)
         cyc("blk_f1", 2'b00, 2'b01, 18'd4, 2'b10, 1'b0, 22'd0);
      cyc("blk_only", 2'b10, 2'b01, 18'd10, 2'b00, 1'b0, 22'd0);
      // Mid-group flux1 still accepted while its own output is full.
      cyc("f1_full_mid", 2'b01, 2'b10, 18'd4, 2'b10, 1'b0, 22'd0);
      cyc("blk_rel", 2'b10, 2'b00, 18'd10, 2'b01, 1'b1, 22'd80);
      for (int k = 0; k < 4; k++)
         cyc("f1_done", 2'b01, 2'b00, 18'd4, 2'b10, (k == 3), 22'h200020);

      // Reset mid-group discards the partial sum.
      for (int k = 0; k < 3; k++)
         cyc("pre_rst", 2'b10, 2'b00, 18'd1, 2'b01, 1'b0, 22'd0);
      rst = 1'b1;
      cyc("mid_rst", 2'b00, 2'b00, 18'd1, 2'b00, 1'b0, 22'd0);
      rst = 1'b0;
      for (int k = 1; k <= 8; k++)
         cyc("post_rst", 2'b10, 2'b00, 18'd2, 2'b01, (k == 8), 22'd16);

      // Sixteen -30 per flux, fluxes alternating -> two -240 sums each.
      for (int k = 0; k < 32; k++) begin
         if (k % 2 == 0)
            cyc("neg_f0", 2'b10, 2'b00, 18'h3FFE2, 2'b01, (k == 14 || k == 30), 22'h1FFF10);
         else
            cyc("neg_f1", 2'b01, 2'b00, 18'h3FFE2, 2'b10, (k == 15 || k == 31), 22'h3FFF10);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/acc_prod_9.md
ACC_PROD_9 -- requirements
Module: acc_prod_9

Interface
REQ-001 SHALL have parameter FLUX, default 2, meaning number of tagged data fluxes (FLUX >= 2).
REQ-002 SHALL have parameter TAPS, default 8, meaning number of consecutive products summed per output (2..16).
REQ-003 SHALL have derived parameters TAG_WIDTH = $clog2(FLUX), DATA_WIDTH_PROD = 18, DATA_WIDTH_SUM = DATA_WIDTH_PROD + $clog2(TAPS).
REQ-004 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port read_port_prod  read_interface.actor  DATA_WIDTH_PROD+TAG_WIDTH  product stream from mul_9; empty[FLUX-1:0] in, read[FLUX-1:0] out, dout in.
REQ-007 SHALL have port write_port_sum  write_interface.actor  DATA_WIDTH_SUM+TAG_WIDTH  tap-sum stream; full[FLUX-1:0] in, write out, din out.

Function
REQ-008 SHALL keep per flux i a signed accumulator acc[i] (DATA_WIDTH_SUM bits) and a tap counter cnt[i] ($clog2(TAPS) bits, minimum 1).
REQ-009 SHALL treat product as signed: dout[DATA_WIDTH_PROD-1:0], sign-extended to DATA_WIDTH_SUM; input tag bits ignored.
REQ-010 SHALL define flux i eligible when empty[i]==0 and (cnt[i] < TAPS-1 or full[i]==0).
REQ-011 SHALL select per cycle the lowest-index eligible flux (fixed priority); at most one flux serviced per cycle.
REQ-012 SHALL, when no flux eligible, drive all read[i]=0, write=0, din don't-care, and leave all state unchanged.
REQ-013 SHALL, for selected flux t, assert read[t]=1 combinationally in the same cycle; read[i]=0 for all i != t.
REQ-014 SHALL, when cnt[t] < TAPS-1: next acc[t] = acc[t] + prod, next cnt[t] = cnt[t]+1, write=0.
REQ-015 SHALL, when cnt[t] == TAPS-1: write=1 same cycle, din = {t, acc[t] + prod}, next acc[t] = 0, next cnt[t] = 0.
REQ-016 SHALL have zero-cycle latency from accepted final product to write strobe (combinational path read->write, matching mul_9 handshake style).
REQ-017 SHALL never overflow: DATA_WIDTH_SUM holds TAPS * (-2^17) .. TAPS * (2^17-1) exactly; no saturation, no rounding.
REQ-018 SHALL, when full[t]==1 and cnt[t]==TAPS-1, not read flux t (product stays in FIFO) while other eligible fluxes proceed.
REQ-019 SHALL, when full[t]==1 and cnt[t] < TAPS-1, still accept and accumulate flux t (no write needed).
REQ-020 SHALL not modify acc/cnt of any flux other than the selected one in a cycle.
REQ-021 SHALL never assert read[i] while empty[i]==1 nor write while full[tag]==1.
REQ-022 SHALL keep each flux's output order identical to its input grouping (product groups never interleave across fluxes within one sum).

Reset
REQ-023 SHALL, while rst==1 at a clock edge, set acc[i]=0 and cnt[i]=0 for all i.
REQ-024 SHALL drive read=0 and write=0 during any cycle in which rst==1, regardless of empty/full.
REQ-025 SHALL discard partial sums on reset mid-group; first product after reset starts a new group at cnt=0.

Verification
REQ-026 SHALL pass: flux0 products 1,2,3,4,5,6,7,8 (TAPS=8), full=0 -> single write din={0, 36} on 8th read cycle; acc[0]=0, cnt[0]=0 after.
REQ-027 SHALL pass: flux1 eight products of -131072 -> din={1, -1048576} (21-bit 0x100000), no overflow.
REQ-028 SHALL pass: both fluxes non-empty every cycle -> flux0 serviced each cycle; flux1 serviced only when empty[0]=1; sums per flux independent and correct.
REQ-029 SHALL pass: flux0 at cnt=7, full[0]=1, flux1 non-empty -> read[0]=0, flux1 accumulated; full[0] drops -> flux0 final read+write same cycle with correct sum.
REQ-030 SHALL pass: rst pulse after 3 of 8 flux0 products (1,1,1) then products 2 x8 -> single write {0, 16}; no write of stale partial 3.
REQ-031 SHALL pass: end-to-end mul_9 -> acc_prod_9, ext_size=4, coeff=-3, opA=10 constant -> 16 products of -30, two sums of -240 per flux in order.
